ym_recorder: RTL and testbench
==============================

# ym_recorder

Captures YM2149 register writes issued by the CPU and stores them as 50/60 Hz frame dumps in RAM, in the non-interleaved 16-byte-per-frame layout the music engine's player reads as frame data. It snoops the same register-write bus that drives the PSG and keeps a 14-register shadow copy. On every frame tick it writes one snapshot record to RAM. CPU control uses a 4-byte register window that matches the player's control window: command byte plus a 24-bit start address.

## Interface
- RAM_WIDTH, 17: RAM address width.
- FRAME_CYCLES_50, 480000: clk cycles per frame at 50 Hz.
- FRAME_CYCLES_60, 400000: clk cycles per frame at 60 Hz.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ctrl_addr  in  2  control register index
- ctrl_data_in  in  8  control write data
- ctrl_write  in  1  control write strobe; one write per cycle
- psg_addr  in  4  snooped PSG register index
- psg_data  in  8  snooped PSG write data
- psg_wr  in  1  snooped PSG write strobe
- ram_addr  out  RAM_WIDTH  capture RAM byte address
- ram_data_out  out  8  capture RAM write data
- ram_wr  out  1  capture RAM write enable
- recording  out  1  capture active
- full  out  1  capture stopped because RAM end was reached
- overrun  out  1  sticky; at least one frame tick was dropped
- frame_count  out  16  records written since last start; saturates at 0xFFFF

## Operation
- Control registers:
  - reg0 is the command register: 1 = start at 50 Hz, 3 = start at 60 Hz, 2 = stop. Other values are cleared with no effect.
  - reg1..3 hold the base address, big-endian, truncated to RAM_WIDTH. The low 4 bits are forced to 0.
- Command consumption:
  - A nonzero reg0 is consumed (cleared to 0) only in state IDLE or WAIT. During DUMP it stays pending.
  - A ctrl_write in the same cycle as consumption wins: the new value is stored and the command is not consumed.
- Start command:
  - Clears the shadow registers, env_written, frame_count, full, overrun and the frame timer.
  - Sets next_addr to the base address, sets recording to 1, and enters WAIT.
- Stop command: recording goes to 0 and the state goes to IDLE. A record in progress is always finished first, because commands are not consumed during DUMP.
- Shadow registers:
  - A psg_wr with psg_addr 0..13 stores psg_data ANDed with the register mask. Writes to 14/15 are ignored. Snooping happens in every state.
  - Masks: R0 FF, R1 0F, R2 FF, R3 0F, R4 FF, R5 0F, R6 1F, R7 FF, R8 1F, R9 1F, R10 1F, R11 FF, R12 FF, R13 0F.
  - A write to R13 sets env_written.
- Frame timer:
  - Runs only while recording. Period is FRAME_CYCLES_50 or FRAME_CYCLES_60 per the start command.
  - It counts 0..N-1 and pulses tick on N-1, then wraps to 0.
- States:
  - IDLE: not recording.
  - WAIT: on tick, latch snapshot = shadow, latch snap_env = env_written, clear env_written, and go to DUMP with byte index 0.
  - DUMP: 16 cycles, one byte per cycle. ram_addr = next_addr + index, ram_wr = 1.
    - Byte layout: bytes 0..12 = snapshot R0..R12. Byte 13 = snap_env ? R13 : 0xFF. Bytes 14,15 = 0x00.
    - After byte 15: next_addr += 16, frame_count += 1 (saturating), and return to WAIT.
- Simultaneous psg_wr and tick in the same cycle: the snapshot takes the pre-write shadow value. The write, and any env_written it sets, belong to the next frame.
- A tick while in DUMP is dropped and sets overrun. The timer keeps running.
- Full condition:
  - If next_addr + 16 carries out of RAM_WIDTH bits after a record completes, go to IDLE with full = 1 and recording = 0.
  - The last record occupies the top 16 bytes. No write ever wraps to address 0.
- reset: aborts immediately, including mid-DUMP. The state goes to IDLE and reg0..3 are cleared.

## Timing
- Reset values:
  - ram_wr 0, ram_addr 0, ram_data_out 0.
  - recording 0, full 0, overrun 0, frame_count 0.
  - All shadow registers, the snapshot and env_written are 0. The state is IDLE.
- All outputs are registered.
- Command latency: a reg0 write at cycle C is consumed at C+1. recording = 1 is visible from C+2.
- Tick at cycle T:
  - The snapshot is taken at T.
  - ram_wr is high for cycles T+1..T+16, with byte k presented at T+1+k.
  - frame_count and next_addr update visibly at T+17. The state is WAIT at T+17.
- A psg_wr is visible in the shadow one cycle later.

## Test plan
- Start 50 Hz with base 0x000100 and FRAME_CYCLES_50 = 64. Write R0 = 0x5A and R1 = 0xFF, then wait for one tick. Required: RAM 0x100 = 5A, 0x101 = 0F, 0x102..0x10C = 00, 0x10D = FF, 0x10E/F = 00, frame_count = 1.
- Write R13 = 0x1E in frame 1 and nothing in frame 2. Required: record 1 byte 13 = 0E, record 2 byte 13 = FF; all other bytes repeat the previous values.
- psg_wr R8 = 0x0C in the exact tick cycle. Required: the current record's byte 8 holds the old value; the next record's byte 8 = 0C.
- Base = 2^17 − 32. Required: exactly two records written (last ram_addr 0x1FFFF), then full = 1, recording = 0, and no further ram_wr.
- Stop command issued at DUMP byte 3. Required: all 16 bytes written, then IDLE. A separate run asserting reset at DUMP byte 3 requires ram_wr = 0 the next cycle and all outputs at reset values.
- FRAME_CYCLES_60 = 10, 60 Hz start. Required: overrun = 1 after the first dropped tick, and records remain 16 bytes and contiguous.

Source files
------------

// File: rtl/ym_recorder.sv
// ym_recorder: snoops YM2149 register writes and dumps one
// 16-byte shadow snapshot per 50/60 Hz frame into capture RAM.
module ym_recorder #(
  parameter int RAM_WIDTH       = 17,
  parameter int FRAME_CYCLES_50 = 480000,
  parameter int FRAME_CYCLES_60 = 400000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           ctrl_addr,
  input  logic [7:0]           ctrl_data_in,
  input  logic                 ctrl_write,
  input  logic [3:0]           psg_addr,
  input  logic [7:0]           psg_data,
  input  logic                 psg_wr,
  output logic [RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]           ram_data_out,
  output logic                 ram_wr,
  output logic                 recording,
  output logic                 full,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  localparam int NMAX = (FRAME_CYCLES_50 > FRAME_CYCLES_60) ?
                        FRAME_CYCLES_50 : FRAME_CYCLES_60;
  localparam int TW = $clog2(NMAX) + 1;
  localparam logic [TW-1:0] LAST50 = TW'(FRAME_CYCLES_50 - 1);
  localparam logic [TW-1:0] LAST60 = TW'(FRAME_CYCLES_60 - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DUMP} state_e;

  state_e                 state_q;
  logic [7:0]             cmd_q;
  logic [23:0]            base_q;
  logic [13:0][7:0]       shadow_q;
  logic [13:0][7:0]       snap_q;
  logic                   env_q;
  logic                   snap_env_q;
  logic                   rate60_q;
  logic [3:0]             idx_q;
  logic [RAM_WIDTH-1:0]   next_addr_q;
  logic [TW-1:0]          timer_q;
  logic [RAM_WIDTH-1:0]   ram_addr_q;
  logic [7:0]             ram_data_q;
  logic                   ram_wr_q;
  logic                   recording_q;
  logic                   full_q;
  logic                   overrun_q;
  logic [15:0]            frame_count_q;

  logic                   cmd_wr;
  logic                   consume;
  logic                   start;
  logic                   stop;
  logic                   tick;
  logic                   snap_take;
  logic [TW-1:0]          last_cnt;
  logic [3:0]             idx_d;
  logic [RAM_WIDTH-1:0]   base_addr;
  logic [RAM_WIDTH:0]     addr_end;
  logic                   unused_base;

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
      default:                 return 8'hFF;
    endcase
  endfunction

  // Byte k of a frame record; R13 reads FF unless rewritten
  function automatic logic [7:0] rec_byte(
    input logic [3:0]       k,
    input logic [13:0][7:0] r,
    input logic             env
  );
    if (k < 4'd13)       return r[k];
    else if (k == 4'd13) return env ? r[13] : 8'hFF;
    else                 return 8'h00;
  endfunction

  assign cmd_wr    = ctrl_write && (ctrl_addr == 2'd0);
  assign consume   = (cmd_q != 8'd0) && (state_q != S_DUMP) && !cmd_wr;
  assign start     = consume && (cmd_q == 8'd1 || cmd_q == 8'd3);
  assign stop      = consume && (cmd_q == 8'd2);
  assign last_cnt  = rate60_q ? LAST60 : LAST50;
  assign tick      = recording_q && (timer_q == last_cnt);
  assign snap_take = tick && (state_q == S_WAIT) && !start && !stop;
  assign idx_d     = idx_q + 4'd1;
  assign base_addr = {base_q[RAM_WIDTH-1:4], 4'h0};
  assign addr_end  = {1'b0, next_addr_q} + (RAM_WIDTH+1)'(16);
  assign unused_base = ^base_q;

  assign ram_addr     = ram_addr_q;
  assign ram_data_out = ram_data_q;
  assign ram_wr       = ram_wr_q;
  assign recording    = recording_q;
  assign full         = full_q;
  assign overrun      = overrun_q;
  assign frame_count  = frame_count_q;

  // Control window: command byte plus big-endian base address
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= 8'd0;
      base_q <= 24'd0;
    end else begin
      if (consume) cmd_q <= 8'd0;
      if (ctrl_write) begin
        case (ctrl_addr)
          2'd0:    cmd_q          <= ctrl_data_in;
          2'd1:    base_q[23:16]  <= ctrl_data_in;
          2'd2:    base_q[15:8]   <= ctrl_data_in;
          default: base_q[7:0]    <= ctrl_data_in;
        endcase
      end
    end
  end

  // Shadow copy of PSG registers; a write beats the snapshot clear
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      env_q    <= 1'b0;
    end else begin
      if (start) begin
        shadow_q <= '0;
        env_q    <= 1'b0;
      end else if (snap_take) begin
        env_q <= 1'b0;
      end
      if (psg_wr && psg_addr < 4'd14) begin
        shadow_q[psg_addr] <= psg_data & reg_mask(psg_addr);
        if (psg_addr == 4'd13) env_q <= 1'b1;
      end
    end
  end

  // Frame timer, free-running while recording
  always_ff @(posedge clk) begin
    if (reset || start || !recording_q) timer_q <= '0;
    else if (timer_q == last_cnt)       timer_q <= '0;
    else                                timer_q <= timer_q + 1'b1;
  end

  // Capture FSM with registered RAM port and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      snap_q        <= '0;
      snap_env_q    <= 1'b0;
      rate60_q      <= 1'b0;
      idx_q         <= 4'd0;
      next_addr_q   <= '0;
      ram_addr_q    <= '0;
      ram_data_q    <= 8'd0;
      ram_wr_q      <= 1'b0;
      recording_q   <= 1'b0;
      full_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      if (tick && state_q == S_DUMP) overrun_q <= 1'b1;
      if (start) begin
        state_q       <= S_WAIT;
        rate60_q      <= (cmd_q == 8'd3);
        next_addr_q   <= base_addr;
        recording_q   <= 1'b1;
        full_q        <= 1'b0;
        overrun_q     <= 1'b0;
        frame_count_q <= 16'd0;
      end else if (stop) begin
        state_q     <= S_IDLE;
        recording_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_WAIT: begin
            if (snap_take) begin
              snap_q     <= shadow_q;
              snap_env_q <= env_q;
              idx_q      <= 4'd0;
              state_q    <= S_DUMP;
              ram_wr_q   <= 1'b1;
              ram_addr_q <= next_addr_q;
              ram_data_q <= rec_byte(4'd0, shadow_q, env_q);
            end
          end
          S_DUMP: begin
            if (idx_q == 4'd15) begin
              ram_wr_q    <= 1'b0;
              next_addr_q <= addr_end[RAM_WIDTH-1:0];
              if (frame_count_q != 16'hFFFF)
                frame_count_q <= frame_count_q + 16'd1;
              if (addr_end[RAM_WIDTH]) begin
                state_q     <= S_IDLE;
                full_q      <= 1'b1;
                recording_q <= 1'b0;
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              idx_q      <= idx_d;
              ram_addr_q <= next_addr_q + RAM_WIDTH'(idx_d);
              ram_data_q <= rec_byte(idx_d, snap_q, snap_env_q);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ym_recorder.sv
// tb_ym_recorder: directed bench for ym_recorder with
// a byte-level RAM model and hand-computed frame records.
module tb_ym_recorder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ctrl_addr = 2'd0;
  logic [7:0]  ctrl_data_in = 8'd0;
  logic        ctrl_write = 1'b0;
  logic [3:0]  psg_addr = 4'd0;
  logic [7:0]  psg_data = 8'd0;
  logic        psg_wr = 1'b0;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data_out;
  logic        ram_wr;
  logic        recording;
  logic        full;
  logic        overrun;
  logic [15:0] frame_count;

  ym_recorder #(
    .RAM_WIDTH(17),
    .FRAME_CYCLES_50(64),
    .FRAME_CYCLES_60(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctrl_addr(ctrl_addr),
    .ctrl_data_in(ctrl_data_in),
    .ctrl_write(ctrl_write),
    .psg_addr(psg_addr),
    .psg_data(psg_data),
    .psg_wr(psg_wr),
    .ram_addr(ram_addr),
    .ram_data_out(ram_data_out),
    .ram_wr(ram_wr),
    .recording(recording),
    .full(full),
    .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem [int];
  int          wr_cnt = 0;
  int          n_rise = 0;
  int          rise_cyc = 0;
  int          contig_bad = 0;
  logic [16:0] last_addr = '0;
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      if (wr_cnt != 0 && ram_addr != 17'(last_addr + 17'd1))
        contig_bad++;
      mem[int'(ram_addr)] = ram_data_out;
      wr_cnt++;
      last_addr = ram_addr;
      if (!prev_wr) begin
        n_rise++;
        rise_cyc = cyc;
      end
    end
    prev_wr = ram_wr;
  end

  typedef struct {
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h5C;
  endfunction

  function automatic void push_rec(input int a, input logic [127:0] b);
    for (int k = 0; k < 16; k++) begin
      vec_t v;
      v.addr = a + k;
      v.exp  = b[127-8*k -: 8];
      tbl.push_back(v);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick1;
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_now(input logic [1:0] a, input logic [7:0] d);
    ctrl_addr = a; ctrl_data_in = d; ctrl_write = 1'b1;
    tick1;
    ctrl_write = 1'b0;
  endtask

  task automatic psg_now(input logic [3:0] a, input logic [7:0] d);
    psg_addr = a; psg_data = d; psg_wr = 1'b1;
    tick1;
    psg_wr = 1'b0;
  endtask

  task automatic set_base(input logic [23:0] b);
    ctrl_now(2'd1, b[23:16]);
    ctrl_now(2'd2, b[15:8]);
    ctrl_now(2'd3, b[7:0]);
  endtask

  task automatic goto_cycle(input int t);
    int g = 0;
    while (cyc < t && g < 5000) begin
      tick1;
      g++;
    end
    chk("goto_cycle", cyc, t);
  endtask

  task automatic wait_rise(input string nm);
    int old = n_rise;
    int g = 0;
    while (n_rise == old && g < 400) begin
      @(negedge clk); #1;
      g++;
    end
    chk({nm, " record start"}, 32'(n_rise != old), 1);
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while (ram_wr && g < 40) begin
      @(negedge clk); #1;
      g++;
    end
    chk({nm, " record end"}, ram_wr, 0);
  endtask

  initial begin
    int c0, r, r1, w0, cb0;

    push_rec(32'h100, 128'h5A0F_0000_0000_0000_0000_0000_00FF_0000);
    push_rec(32'h110, 128'h5A0F_0000_0000_0000_0000_0000_000E_0000);
    push_rec(32'h120, 128'h5A0F_0000_0000_0000_0000_0000_00FF_0000);
    push_rec(32'h130, 128'h5A0F_0000_0000_1F00_1300_0000_00FF_0000);
    push_rec(32'h140, 128'h5A0F_0000_0000_1F00_0C00_0000_00FF_0000);
    push_rec(32'h150, 128'h5A0F_0000_0000_1F00_0C00_0000_00FF_0000);

    repeat (3) tick1;
    reset = 1'b0;
    chk("rst ram_wr", ram_wr, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_data", ram_data_out, 0);
    chk("rst recording", recording, 0);
    chk("rst full", full, 0);
    chk("rst overrun", overrun, 0);
    chk("rst frame_count", frame_count, 0);

    // 50 Hz run at 0x100: records 0..5
    set_base(24'h000100);
    c0 = cyc;
    ctrl_now(2'd0, 8'd1);
    chk("start lat C+1", recording, 0);
    tick1;
    chk("start lat C+2", recording, 1);
    psg_now(4'd0, 8'h5A);
    psg_now(4'd1, 8'hFF);
    wait_rise("rec0");
    chk("rec0 rise cycle", rise_cyc, c0 + 66);
    wait_done("rec0");
    chk("rec0 frame_count", frame_count, 1);
    psg_now(4'd13, 8'h1E);
    psg_now(4'd14, 8'h77);
    psg_now(4'd15, 8'h55);
    wait_rise("rec1");
    wait_done("rec1");
    chk("rec1 frame_count", frame_count, 2);
    wait_rise("rec2");
    r = rise_cyc;
    wait_done("rec2");
    psg_now(4'd8, 8'h33);
    psg_now(4'd6, 8'hFF);
    goto_cycle(r - 1 + 64);
    psg_now(4'd8, 8'h0C);
    wait_rise("rec3");
    chk("rec3 rise cycle", rise_cyc, r + 64);
    wait_done("rec3");
    wait_rise("rec4");
    wait_done("rec4");
    chk("rec4 frame_count", frame_count, 5);
    w0 = wr_cnt;
    wait_rise("rec5");
    goto_cycle(rise_cyc + 3);
    ctrl_now(2'd0, 8'd2);
    wait_done("rec5");
    chk("stop rec bytes", wr_cnt - w0, 16);
    chk("stop frame_count", frame_count, 6);
    chk("stop pending rec", recording, 1);
    tick1;
    chk("stop recording", recording, 0);
    repeat (150) tick1;
    chk("stop no writes", wr_cnt - w0, 16);

    foreach (tbl[i])
      chk($sformatf("mem[%05h]", tbl[i].addr), rd(tbl[i].addr), tbl[i].exp);

    // Full: base at top-32, exactly two records
    set_base(24'h01FFE0);
    w0 = wr_cnt;
    ctrl_now(2'd0, 8'd1);
    wait_rise("full rec0");
    wait_done("full rec0");
    chk("full rec0 last", last_addr, 17'h1FFEF);
    chk("full not yet", full, 0);
    wait_rise("full rec1");
    wait_done("full rec1");
    chk("full last addr", last_addr, 17'h1FFFF);
    chk("full flag", full, 1);
    chk("full recording", recording, 0);
    chk("full frame_count", frame_count, 2);
    chk("full bytes", wr_cnt - w0, 32);
    chk("full cleared R0", rd(32'h1FFE0), 8'h00);
    chk("full byte13", rd(32'h1FFED), 8'hFF);
    chk("full top byte", rd(32'h1FFFF), 8'h00);
    chk("full no wrap", rd(0), 8'h5C);
    repeat (150) tick1;
    chk("full no writes", wr_cnt - w0, 32);

    // Reset in the middle of a record
    set_base(24'h000200);
    w0 = wr_cnt;
    ctrl_now(2'd0, 8'd1);
    tick1;
    chk("restart full clr", full, 0);
    wait_rise("rst rec");
    goto_cycle(rise_cyc + 3);
    reset = 1'b1;
    tick1;
    reset = 1'b0;
    chk("midrst ram_wr", ram_wr, 0);
    chk("midrst ram_addr", ram_addr, 0);
    chk("midrst ram_data", ram_data_out, 0);
    chk("midrst recording", recording, 0);
    chk("midrst full", full, 0);
    chk("midrst overrun", overrun, 0);
    chk("midrst frame_count", frame_count, 0);
    chk("midrst bytes", wr_cnt - w0, 4);
    repeat (100) tick1;
    chk("midrst no writes", wr_cnt - w0, 4);

    // 60 Hz with 10-cycle frames; base cleared by reset
    w0 = wr_cnt;
    c0 = cyc;
    ctrl_now(2'd0, 8'd3);
    wait_rise("r60 rec0");
    chk("r60 rise cycle", rise_cyc, c0 + 12);
    chk("r60 overrun early", overrun, 0);
    wait_done("r60 rec0");
    chk("r60 overrun", overrun, 1);
    chk("r60 rec0 last", last_addr, 17'h0000F);
    chk("r60 byte0", rd(0), 8'h00);
    chk("r60 byte13", rd(13), 8'hFF);
    cb0 = contig_bad;
    r1 = rise_cyc;
    wait_rise("r60 rec1");
    chk("r60 spacing", rise_cyc - r1, 20);
    wait_done("r60 rec1");
    wait_rise("r60 rec2");
    wait_done("r60 rec2");
    wait_rise("r60 rec3");
    wait_done("r60 rec3");
    chk("r60 contiguous", contig_bad - cb0, 0);
    chk("r60 last addr", last_addr, 17'h0003F);
    chk("r60 bytes", wr_cnt - w0, 64);
    chk("r60 frame_count", frame_count, 4);
    chk("r60 overrun sticky", overrun, 1);
    ctrl_now(2'd0, 8'd2);
    tick1;
    chk("r60 stopped", recording, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
